// File: rtl/beta_pkg.sv
// Shared opcodes, bubble instruction word and memory-FSM state type for the
// beta pipeline memory stage.
package beta_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h83FF_FFFF;

  localparam logic [5:0] OP_LD  = 6'b011000;
  localparam logic [5:0] OP_ST  = 6'b011001;
  localparam logic [5:0] OP_JMP = 6'b011011;
  localparam logic [5:0] OP_BEQ = 6'b011100;
  localparam logic [5:0] OP_BNE = 6'b011101;
  localparam logic [5:0] OP_LDR = 6'b011111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } mem_state_t;

  function automatic logic is_read(input logic [5:0] op);
    return (op == OP_LD) || (op == OP_LDR);
  endfunction

  function automatic logic is_write(input logic [5:0] op);
    return op == OP_ST;
  endfunction

  function automatic logic is_mem(input logic [5:0] op);
    return is_read(op) || is_write(op);
  endfunction

  // Control-transfer ops write the return address (pc+4) back.
  function automatic logic is_branch(input logic [5:0] op);
    return (op == OP_JMP) || (op == OP_BEQ) || (op == OP_BNE);
  endfunction

endpackage

// File: rtl/beta_mem_ctrl.sv
// Request/acknowledge sequencer for one data-memory transaction per memory
// instruction held in the stage.
module beta_mem_ctrl
  import beta_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic i_mem_op,
  input  logic i_mem_ack,
  output logic o_mem_req,
  output logic o_stall,
  output logic o_capture
);

  mem_state_t r_state;
  logic       r_mem_req;

  // NOTE: sequential state uses non-blocking assignments and an asynchronous
  // reset, so a reset mid-transaction drops the request without waiting for clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_mem_req <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_mem_op) begin
            r_state   <= S_BUSY;
            r_mem_req <= 1'b1;
          end
        end
        S_BUSY: begin
          if (i_mem_ack) begin
            r_state   <= S_DONE;
            r_mem_req <= 1'b0;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state   <= S_IDLE;
          r_mem_req <= 1'b0;
        end
      endcase
    end
  end

  // DONE is the single cycle in which a memory op may leave the stage.
  assign o_stall   = i_mem_op && (r_state != S_DONE);
  assign o_capture = (r_state == S_BUSY) && i_mem_ack;
  assign o_mem_req = r_mem_req;

endmodule

// File: rtl/beta_mem_stage.sv
// Beta MEM pipeline stage: stage registers, result selection and the
// data-memory port, sequenced by beta_mem_ctrl.
module beta_mem_stage
  import beta_pkg::*;
#(
  parameter logic [31:0] NOP = NOP_INSTR
)
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        annul,
  input  logic [31:0] pcin,
  input  logic [31:0] irin,
  input  logic [31:0] yin,
  input  logic [31:0] din,
  output logic        stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [31:0] pcout,
  output logic [31:0] irout,
  output logic [31:0] resout
);

  logic [31:0] r_pc;
  logic [31:0] r_ir;
  logic [31:0] r_y;
  logic [31:0] r_d;
  logic [31:0] r_rdata_q;

  logic [5:0]  w_op;
  logic        w_mem_op;
  logic        w_stall;
  logic        w_mem_req;
  logic        w_capture;

  assign w_op     = r_ir[31:26];
  assign w_mem_op = is_mem(w_op);

  beta_mem_ctrl u_ctrl (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_mem_op  (w_mem_op),
    .i_mem_ack (mem_ack),
    .o_mem_req (w_mem_req),
    .o_stall   (w_stall),
    .o_capture (w_capture)
  );

  // annul is only looked at on a loading edge, so an in-flight op always completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc <= '0;
      r_ir <= NOP;
      r_y  <= '0;
      r_d  <= '0;
    end else if (!w_stall) begin
      r_pc <= pcin;
      r_ir <= annul ? NOP : irin;
      r_y  <= yin;
      r_d  <= din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdata_q <= '0;
    end else if (w_capture && is_read(w_op)) begin
      r_rdata_q <= mem_rdata;
    end
  end

  // NOTE: the combinational result mux assigns its default first so no path
  // leaves resout unassigned and no latch is inferred.
  always_comb begin
    resout = r_y;
    if (is_read(w_op)) begin
      resout = r_rdata_q;
    end else if (is_branch(w_op)) begin
      resout = r_pc;
    end
  end

  assign stall     = w_stall;
  assign mem_req   = w_mem_req;
  assign mem_we    = w_mem_req && is_write(w_op);
  assign mem_addr  = r_y;
  assign mem_wdata = r_d;
  // A bubble goes to write-back while stalled so each instruction commits once.
  assign irout     = w_stall ? NOP : r_ir;
  assign pcout     = r_pc;

endmodule

// File: tb/tb_beta_mem_stage.sv
// Randomized bench for beta_mem_stage: an in-order instruction model predicts
// each commit and each memory transaction; a memory responder adds random wait states.
module tb_beta_mem_stage;
  import beta_pkg::*;

  localparam logic [31:0] NOP_W   = 32'h83FF_FFFF;
  localparam logic [5:0]  OP_ADDC = 6'b110000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        annul;
  logic [31:0] pcin, irin, yin, din;
  logic        stall, mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [31:0] pcout, irout, resout;

  always #5 clk = ~clk;

  beta_mem_stage #(.NOP(NOP_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .annul     (annul),
    .pcin      (pcin),
    .irin      (irin),
    .yin       (yin),
    .din       (din),
    .stall     (stall),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .pcout     (pcout),
    .irout     (irout),
    .resout    (resout)
  );

  typedef struct {
    logic [31:0] ir;
    logic [31:0] pc;
    logic [31:0] res;
  } commit_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
  } txn_t;

  commit_t     exp_q[$];
  txn_t        txn_q[$];
  logic [31:0] ref_mem [logic [31:0]];
  logic [31:0] ext_mem [logic [31:0]];

  int n_vec = 0;
  int n_err = 0;
  int n_commit = 0;
  int n_txn = 0;
  int wait_left = -1;
  bit pending = 1'b0;

  commit_t     c;
  txn_t        t;
  logic [5:0]  op_tab [8];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_init(input logic [31:0] a);
    return a ^ 32'hC0DE_5A00;
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : mem_init(a);
  endfunction

  function automatic logic [31:0] ext_rd(input logic [31:0] a);
    return ext_mem.exists(a) ? ext_mem[a] : mem_init(a);
  endfunction

  // Architectural effect of the instruction about to be loaded, in program order.
  task automatic model_push();
    commit_t    e;
    txn_t       x;
    logic [5:0] op;
    op    = irin[31:26];
    e.pc  = pcin;
    e.ir  = annul ? NOP_W : irin;
    e.res = yin;
    if (!annul) begin
      if (op == OP_LD || op == OP_LDR) begin
        e.res = ref_rd(yin);
        x = '{addr: yin, wdata: din, we: 1'b0};
        txn_q.push_back(x);
      end else if (op == OP_ST) begin
        ref_mem[yin] = din;
        x = '{addr: yin, wdata: din, we: 1'b1};
        txn_q.push_back(x);
      end else if (op == OP_JMP || op == OP_BEQ || op == OP_BNE) begin
        e.res = pcin;
      end
    end
    exp_q.push_back(e);
  endtask

  task automatic gen_instr();
    logic [5:0] op;
    op   = op_tab[$urandom_range(0, 7)];
    irin = {op, 26'($urandom)};
    pcin = {$urandom} & 32'hFFFF_FFFC;
    din  = $urandom;
    if (op == OP_LD || op == OP_LDR || op == OP_ST)
      yin = 32'h100 + 32'($urandom_range(0, 15)) * 4;
    else
      yin = $urandom;
  endtask

  initial begin
    op_tab = '{OP_LD, OP_LDR, OP_ST, OP_JMP, OP_BEQ, OP_BNE, OP_ADDC, 6'b000000};
    rst_n = 1'b0; annul = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
    pcin = '0; irin = NOP_W; yin = '0; din = '0;

    // Reset values, held across a clock edge.
    #12;
    check("rst_stall",  stall,   1'b0);
    check("rst_req",    mem_req, 1'b0);
    check("rst_irout",  irout,   NOP_W);
    check("rst_pcout",  pcout,   32'h0);
    check("rst_resout", resout,  32'h0);

    // LD, then reset while the request is outstanding.
    @(negedge clk);
    rst_n = 1'b1;
    irin  = {OP_LD, 26'h0};
    yin   = 32'h100;
    pcin  = 32'h10;
    @(negedge clk);
    irin = NOP_W; yin = '0; pcin = '0;
    check("ld_stall0", stall,   1'b1);
    check("ld_irout0", irout,   NOP_W);
    check("ld_noreq0", mem_req, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (mem_req) break;
    end
    check("ld_req",  mem_req,  1'b1);
    check("ld_addr", mem_addr, 32'h100);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_req",   mem_req, 1'b0);
    check("midrst_irout", irout,   NOP_W);
    check("midrst_stall", stall,   1'b0);
    @(negedge clk);
    rst_n     = 1'b1;
    mem_ack   = 1'b1;
    mem_rdata = 32'hDEAD_BEEF;
    repeat (2) begin
      @(negedge clk);
      check("late_ack_req",    mem_req, 1'b0);
      check("late_ack_stall",  stall,   1'b0);
      check("late_ack_resout", resout,  32'h0);
    end
    mem_ack = 1'b0;

    // Randomized phase; the stage currently holds a NOP with pc=y=0.
    c = '{ir: NOP_W, pc: 32'h0, res: 32'h0};
    exp_q.push_back(c);
    repeat (1500) begin
      @(negedge clk);
      if (!stall) begin
        if (exp_q.size() == 0) begin
          check("commit_extra", 32'h1, 32'h0);
        end else begin
          c = exp_q.pop_front();
          check("irout",  irout,  c.ir);
          check("pcout",  pcout,  c.pc);
          check("resout", resout, c.res);
          n_commit++;
        end
      end else begin
        check("irout_stalled", irout, NOP_W);
      end

      if (mem_req) begin
        if (txn_q.size() == 0) begin
          check("txn_extra", mem_req, 1'b0);
        end else begin
          t = txn_q[0];
          check("mem_addr", mem_addr, t.addr);
          check("mem_we",   mem_we,   t.we);
          if (t.we) check("mem_wdata", mem_wdata, t.wdata);
        end
        if (wait_left < 0) wait_left = $urandom_range(0, 3);
        if (wait_left == 0) begin
          mem_ack = 1'b1;
          if (mem_we) ext_mem[mem_addr] = mem_wdata;
          mem_rdata = ext_rd(mem_addr);
          if (txn_q.size() != 0) void'(txn_q.pop_front());
          n_txn++;
          wait_left = -1;
        end else begin
          mem_ack = 1'b0;
          mem_rdata = $urandom;
          wait_left--;
        end
      end else begin
        // Stray acknowledges while idle must have no effect.
        mem_ack   = ($urandom_range(0, 3) == 0);
        mem_rdata = $urandom;
      end

      if (!pending) begin
        gen_instr();
        pending = 1'b1;
      end
      annul = ($urandom_range(0, 7) == 0);
      if (!stall) begin
        model_push();
        pending = 1'b0;
      end
    end

    check("progress_commits", 32'(n_commit >= 200), 32'h1);
    check("progress_txns",    32'(n_txn >= 50),     32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
